// File: rtl/bus_demux_1x4.sv
// Sequential 1-to-4 request demultiplexer: one core request in flight, steered to
// one of four targets, with a one-cycle response carrying read data or a timeout error.
module bus_demux_1x4 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Req_Valid,
  output logic                  Req_Ready,
  input  logic                  Req_Write,
  input  logic [1:0]            Selector,
  input  logic [ADDR_WIDTH-1:0] Req_Addr,
  input  logic [DATA_WIDTH-1:0] Req_WData,
  output logic                  Resp_Valid,
  output logic [DATA_WIDTH-1:0] Resp_RData,
  output logic                  Resp_Error,
  output logic [3:0]            T_Valid,
  output logic                  T_Write,
  output logic [ADDR_WIDTH-1:0] T_Addr,
  output logic [DATA_WIDTH-1:0] T_WData,
  input  logic [3:0]            T_Ready,
  input  logic [DATA_WIDTH-1:0] T_RData_0,
  input  logic [DATA_WIDTH-1:0] T_RData_1,
  input  logic [DATA_WIDTH-1:0] T_RData_2,
  input  logic [DATA_WIDTH-1:0] T_RData_3
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  // Last ISSUE cycle's counter value; a ready seen then still counts as success.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t                state;
  logic [1:0]            sel;
  logic [7:0]            wait_count;
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_rdata;

  always_comb begin
    sel_ready = T_Ready[sel];
    case (sel)
      2'd0:    sel_rdata = T_RData_0;
      2'd1:    sel_rdata = T_RData_1;
      2'd2:    sel_rdata = T_RData_2;
      default: sel_rdata = T_RData_3;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= 2'd0;
      wait_count <= 8'd0;
      T_Write    <= 1'b0;
      T_Addr     <= '0;
      T_WData    <= '0;
      Resp_RData <= '0;
      Resp_Error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Req_Valid) begin
            sel        <= Selector;
            T_Write    <= Req_Write;
            T_Addr     <= Req_Addr;
            T_WData    <= Req_WData;
            wait_count <= 8'd0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (sel_ready) begin
            Resp_RData <= T_Write ? '0 : sel_rdata;
            Resp_Error <= 1'b0;
            state      <= RESP;
          end else if (wait_count == LAST_WAIT) begin
            Resp_RData <= '0;
            Resp_Error <= 1'b1;
            state      <= RESP;
          end else begin
            wait_count <= wait_count + 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Req_Ready  = (state == IDLE);
  assign Resp_Valid = (state == RESP);

  for (genvar gi = 0; gi < 4; gi++) begin : g_tvalid
    assign T_Valid[gi] = (state == ISSUE) && (sel == 2'(gi));
  end

endmodule
